// File: rtl/rgb_frame_reader_pkg.sv
// Shared state types and frame constants for the RGB read path.
// The colour-conversion stage imports the same frame geometry from here.
package rgb_frame_reader_pkg;

    localparam logic [17:0] RGB_BASE_ADDR = 18'd146944;
    localparam int          FRAME_WIDTH   = 320;
    localparam int          FRAME_HEIGHT  = 240;
    localparam int          FIFO_DEPTH    = 8;

    typedef enum logic [1:0] {
        S_RD_IDLE,
        S_RD_RUN,
        S_RD_DRAIN,
        S_RD_DONE
    } rd_state_t;

    typedef enum logic {
        S_UP_P0,
        S_UP_P1
    } up_state_t;

    // Two pixels pack into three 16-bit words.
    function automatic int frame_words(input int w, input int h);
        return (w * h * 3) / 2;
    endfunction

endpackage

// File: rtl/sram_word_fifo.sv
// Show-ahead word FIFO between the SRAM read pipe and the pixel unpacker.
// Exposes the two oldest words so a full pixel can be built in one cycle.
module sram_word_fifo
    import rgb_frame_reader_pkg::*;
(
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        i_push,
    input  logic [15:0] i_push_data,
    input  logic [1:0]  i_pop_num,
    output logic [15:0] o_head,
    output logic [15:0] o_next,
    output logic [3:0]  o_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = 4;

    logic [15:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] w_rd_ptr_nxt;

    assign w_rd_ptr_nxt = r_rd_ptr + AW'(1);

    always_ff @(posedge Clock) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= r_rd_ptr + AW'(i_pop_num);
            r_count  <= r_count + CW'(i_push) - CW'(i_pop_num);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_next  = r_mem[w_rd_ptr_nxt];
    assign o_count = r_count;

endmodule

// File: rtl/rgb_frame_reader.sv
// Streams one packed RGB frame out of SRAM and unpacks it into a
// valid/ready pixel stream with start-of-frame / start-of-line flags.
//
// Reader FSM                    | Unpacker FSM
// state      | meaning          | state   | meaning
// S_RD_IDLE  | wait for Enable  | S_UP_P0 | build even pixel from 2 words
// S_RD_RUN   | issuing reads    | S_UP_P1 | build odd pixel from saved R + 1 word
// S_RD_DRAIN | all reads issued, waiting for last pixel hand-off
// S_RD_DONE  | one-cycle Done pulse
module rgb_frame_reader
    import rgb_frame_reader_pkg::*;
#(
    parameter logic [17:0] RGB_BASE = RGB_BASE_ADDR,
    parameter int          WIDTH    = FRAME_WIDTH,
    parameter int          HEIGHT   = FRAME_HEIGHT
)(
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Enable,
    output logic [17:0] SRAM_address,
    input  logic [15:0] SRAM_read_data,
    output logic        SRAM_we_n,
    output logic [15:0] SRAM_write_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [7:0]  pix_R,
    output logic [7:0]  pix_G,
    output logic [7:0]  pix_B,
    output logic        pix_sof,
    output logic        pix_sol,
    output logic        Done
);

    localparam int TOTAL_WORDS = frame_words(WIDTH, HEIGHT);
    localparam int RD_W        = $clog2(TOTAL_WORDS + 1);
    localparam int COL_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ROW_W       = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [RD_W-1:0]  RD_LOAD  = RD_W'(TOTAL_WORDS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    rd_state_t        r_rd_state;
    rd_state_t        w_rd_state_nxt;
    up_state_t        r_up_state;
    up_state_t        w_up_state_nxt;

    logic [17:0]      r_sram_address;
    logic [RD_W-1:0]  r_rd_left;
    logic [1:0]       r_rd_pipe;

    logic [15:0]      w_head;
    logic [15:0]      w_next;
    logic [3:0]       w_count;
    logic [1:0]       w_pop_num;
    logic [4:0]       w_occupancy;
    logic             w_room;
    logic             w_issue;
    logic             w_done;
    logic             w_load;
    logic             w_out_free;
    logic             w_accept;
    logic             w_last_accept;

    logic             r_pix_valid;
    logic             r_pix_last;
    logic             r_sof;
    logic             r_sol;
    logic [7:0]       r_R;
    logic [7:0]       r_G;
    logic [7:0]       r_B;
    logic [7:0]       r_saved_r;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    sram_word_fifo u_fifo (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .i_push      (r_rd_pipe[1]),
        .i_push_data (SRAM_read_data),
        .i_pop_num   (w_pop_num),
        .o_head      (w_head),
        .o_next      (w_next),
        .o_count     (w_count)
    );

    // Every word already fetched or on its way counts against the 8-word budget,
    // including the pair parked in a stalled output register.
    assign w_occupancy = 5'(w_count) + 5'(r_rd_pipe[0]) + 5'(r_rd_pipe[1])
                       + (r_pix_valid ? 5'd2 : 5'd0);
    assign w_room      = (w_occupancy < 5'(FIFO_DEPTH));

    // ---------------- reader FSM ----------------
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_rd_state <= S_RD_IDLE;
        end else begin
            r_rd_state <= w_rd_state_nxt;
        end
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        unique case (r_rd_state)
            S_RD_IDLE:  if (Enable) w_rd_state_nxt = S_RD_RUN;
            S_RD_RUN:   if (w_issue && (r_rd_left == RD_W'(1))) w_rd_state_nxt = S_RD_DRAIN;
            S_RD_DRAIN: if (w_last_accept) w_rd_state_nxt = S_RD_DONE;
            S_RD_DONE:  w_rd_state_nxt = S_RD_IDLE;
            default:    w_rd_state_nxt = S_RD_IDLE;
        endcase
    end

    // The pipe is empty in IDLE, so the first read goes out on the Enable edge.
    always_comb begin
        w_issue = 1'b0;
        w_done  = 1'b0;
        unique case (r_rd_state)
            S_RD_IDLE: w_issue = Enable;
            S_RD_RUN:  w_issue = w_room;
            S_RD_DONE: w_done  = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_sram_address <= '0;
            r_rd_left      <= '0;
            r_rd_pipe      <= '0;
        end else begin
            r_rd_pipe <= {r_rd_pipe[0], w_issue};
            if (w_issue) begin
                if (r_rd_state == S_RD_IDLE) begin
                    r_sram_address <= RGB_BASE;
                    r_rd_left      <= RD_LOAD;
                end else begin
                    r_sram_address <= r_sram_address + 18'd1;
                    r_rd_left      <= r_rd_left - RD_W'(1);
                end
            end
        end
    end

    // ---------------- unpacker FSM ----------------
    assign w_out_free    = !r_pix_valid || pix_ready;
    assign w_accept      = r_pix_valid && pix_ready;
    assign w_last_accept = w_accept && r_pix_last;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_up_state <= S_UP_P0;
        end else begin
            r_up_state <= w_up_state_nxt;
        end
    end

    always_comb begin
        w_up_state_nxt = r_up_state;
        if (w_load) begin
            w_up_state_nxt = (r_up_state == S_UP_P0) ? S_UP_P1 : S_UP_P0;
        end
    end

    always_comb begin
        w_load    = 1'b0;
        w_pop_num = 2'd0;
        unique case (r_up_state)
            S_UP_P0: if (w_out_free && (w_count >= 4'd2)) begin
                w_load    = 1'b1;
                w_pop_num = 2'd2;
            end
            S_UP_P1: if (w_out_free && (w_count >= 4'd1)) begin
                w_load    = 1'b1;
                w_pop_num = 2'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_pix_valid <= 1'b0;
            r_pix_last  <= 1'b0;
            r_sof       <= 1'b0;
            r_sol       <= 1'b0;
            r_R         <= '0;
            r_G         <= '0;
            r_B         <= '0;
            r_saved_r   <= '0;
        end else if (w_load) begin
            r_pix_valid <= 1'b1;
            r_sof       <= (r_col == '0) && (r_row == '0);
            r_sol       <= (r_col == '0);
            r_pix_last  <= (r_col == COL_LAST) && (r_row == ROW_LAST);
            if (r_up_state == S_UP_P0) begin
                r_R       <= w_head[15:8];
                r_G       <= w_head[7:0];
                r_B       <= w_next[15:8];
                r_saved_r <= w_next[7:0];
            end else begin
                r_R <= r_saved_r;
                r_G <= w_head[15:8];
                r_B <= w_head[7:0];
            end
        end else if (w_accept) begin
            r_pix_valid <= 1'b0;
        end
    end

    // Position of the next pixel to be built; wraps fully after the last one.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_load) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    assign SRAM_address    = r_sram_address;
    assign SRAM_we_n       = 1'b1;
    assign SRAM_write_data = 16'd0;
    assign pix_valid       = r_pix_valid;
    assign pix_R           = r_R;
    assign pix_G           = r_G;
    assign pix_B           = r_B;
    assign pix_sof         = r_sof;
    assign pix_sol         = r_sol;
    assign Done            = w_done;

endmodule

// File: tb/tb_rgb_frame_reader.sv
// Bench for rgb_frame_reader on a reduced 8x4 frame placed at the top of SRAM
// so the last read lands on address 262143.
module tb_rgb_frame_reader;

    localparam int          W         = 8;
    localparam int          H         = 4;
    localparam int          NWORDS    = W * H * 3 / 2;
    localparam int          NPIX      = W * H;
    localparam logic [17:0] BASE      = 18'(262144 - NWORDS);
    localparam logic [17:0] LAST_ADDR = 18'd262143;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b1;
    logic        Enable = 1'b0;
    logic        pix_ready = 1'b0;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_read_data = 16'd0;
    logic        SRAM_we_n;
    logic [15:0] SRAM_write_data;
    logic        pix_valid;
    logic [7:0]  pix_R;
    logic [7:0]  pix_G;
    logic [7:0]  pix_B;
    logic        pix_sof;
    logic        pix_sol;
    logic        Done;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [NWORDS];

    typedef struct {
        int          mode;      // 0 ready always, 1 random, 2 every third cycle
        int          en_again;  // loop cycle of an extra Enable pulse, -1 for none
        int          exp_pix;
        int          exp_sol;
        int          exp_sof;
        int          exp_done;
        logic [17:0] exp_last;
    } vec_t;

    vec_t vecs[4];

    rgb_frame_reader #(.RGB_BASE(BASE), .WIDTH(W), .HEIGHT(H)) dut (
        .Clock           (Clock),
        .Resetn          (Resetn),
        .Enable          (Enable),
        .SRAM_address    (SRAM_address),
        .SRAM_read_data  (SRAM_read_data),
        .SRAM_we_n       (SRAM_we_n),
        .SRAM_write_data (SRAM_write_data),
        .pix_valid       (pix_valid),
        .pix_ready       (pix_ready),
        .pix_R           (pix_R),
        .pix_G           (pix_G),
        .pix_B           (pix_B),
        .pix_sof         (pix_sof),
        .pix_sol         (pix_sol),
        .Done            (Done)
    );

    always #5 Clock = ~Clock;

    function automatic logic [15:0] word_at(input logic [17:0] a);
        int idx;
        idx = int'(a) - int'(BASE);
        if (idx >= 0 && idx < NWORDS) return mem[idx];
        return 16'hDEAD;
    endfunction

    // Data requested on edge n is on the bus for the design to capture on edge n+1.
    always @(posedge Clock) SRAM_read_data <= word_at(SRAM_address);

    function automatic logic [25:0] exp_pix(input int k);
        int g, col, row;
        logic [15:0] w0, w1, w2;
        logic [23:0] rgb;
        g = k / 2; col = k % W; row = k / W;
        w0 = mem[3*g]; w1 = mem[3*g+1]; w2 = mem[3*g+2];
        if (k % 2 == 0) rgb = {w0[15:8], w0[7:0], w1[15:8]};
        else            rgb = {w1[7:0], w2[15:8], w2[7:0]};
        return {rgb, (col == 0 && row == 0), (col == 0)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [62:0] outs;
    assign outs = {SRAM_address, SRAM_we_n, SRAM_write_data, pix_valid,
                   pix_R, pix_G, pix_B, pix_sof, pix_sol, Done};
    localparam logic [62:0] RESET_OUTS = {18'd0, 1'b1, 16'd0, 1'b0, 24'd0, 3'b000};

    int cyc = 0;
    int acc_idx, sol_cnt, sof_cnt, done_cnt;
    int first_valid_cyc, first_acc_cyc, last_acc_cyc, fifo_max;
    logic        prev_stall = 1'b0;
    logic [25:0] prev_out = '0;

    always @(posedge Clock) cyc = cyc + 1;

    always @(negedge Clock) begin
        logic [25:0] cur;
        cur = {pix_R, pix_G, pix_B, pix_sof, pix_sol};
        if (!Resetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("stall_hold", {pix_valid, cur}, {1'b1, prev_out});
            if (pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (pix_valid && pix_ready) begin
                if (acc_idx < NPIX) check($sformatf("pixel%0d", acc_idx), cur, exp_pix(acc_idx));
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                last_acc_cyc = cyc;
                acc_idx++;
                sol_cnt += int'(pix_sol);
                sof_cnt += int'(pix_sof);
            end
            if (Done) done_cnt++;
            if (int'(dut.u_fifo.o_count) > fifo_max) fifo_max = int'(dut.u_fifo.o_count);
            prev_stall = pix_valid && !pix_ready;
            prev_out   = cur;
        end
    end

    task automatic clear_counts();
        acc_idx = 0; sol_cnt = 0; sof_cnt = 0; done_cnt = 0;
        first_valid_cyc = -1; first_acc_cyc = -1; last_acc_cyc = -1; fifo_max = 0;
    endtask

    int en_cyc;

    task automatic start_frame(input logic ready);
        clear_counts();
        @(posedge Clock); #1;
        pix_ready = ready;
        Enable = 1'b1;
        en_cyc = cyc;
        @(posedge Clock); #1;
        Enable = 1'b0;
        check("start_addr", SRAM_address, BASE);
    endtask

    task automatic run_frame(input int mode, input int en_again);
        start_frame(mode != 2);
        for (int c = 0; c < 2000 && done_cnt == 0; c++) begin
            case (mode)
                1:       pix_ready = 1'($urandom_range(0, 1));
                2:       pix_ready = (c % 3 == 0);
                default: pix_ready = 1'b1;
            endcase
            Enable = (c == en_again);
            @(posedge Clock); #1;
        end
        Enable = 1'b0;
        pix_ready = 1'b1;
        repeat (6) @(posedge Clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < NWORDS; i++) mem[i] = 16'(i * 16'h0313 + 16'h0A07);
        mem[0] = 16'h1122; mem[1] = 16'h3344; mem[2] = 16'h5566;

        vecs[0] = '{mode: 0, en_again: -1, exp_pix: NPIX, exp_sol: H, exp_sof: 1, exp_done: 1, exp_last: LAST_ADDR};
        vecs[1] = '{mode: 1, en_again: -1, exp_pix: NPIX, exp_sol: H, exp_sof: 1, exp_done: 1, exp_last: LAST_ADDR};
        vecs[2] = '{mode: 2, en_again: -1, exp_pix: NPIX, exp_sol: H, exp_sof: 1, exp_done: 1, exp_last: LAST_ADDR};
        vecs[3] = '{mode: 0, en_again: 20, exp_pix: NPIX, exp_sol: H, exp_sof: 1, exp_done: 1, exp_last: LAST_ADDR};

        clear_counts();
        #1 Resetn = 1'b0;
        #2 check("reset_outputs", outs, RESET_OUTS);
        @(posedge Clock); @(posedge Clock); #1;
        Resetn = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i].mode, vecs[i].en_again);
            check($sformatf("v%0d_pix_count", i), acc_idx, vecs[i].exp_pix);
            check($sformatf("v%0d_sol_count", i), sol_cnt, vecs[i].exp_sol);
            check($sformatf("v%0d_sof_count", i), sof_cnt, vecs[i].exp_sof);
            check($sformatf("v%0d_done_count", i), done_cnt, vecs[i].exp_done);
            check($sformatf("v%0d_last_addr", i), SRAM_address, vecs[i].exp_last);
            check($sformatf("v%0d_fifo_max_le8", i), fifo_max <= 8, 1);
            if (vecs[i].mode == 0 && vecs[i].en_again < 0) begin
                check("first_valid_latency_le5", (first_valid_cyc - en_cyc) <= 5, 1);
                check("span_2_per_3", (last_acc_cyc - first_acc_cyc) <= (3 * NPIX / 2 - 2), 1);
            end
        end

        // Consumer stalled from the start: reads stop at the word budget.
        start_frame(1'b0);
        repeat (100) @(posedge Clock);
        #1;
        check("stall_addr", SRAM_address, BASE + 18'd7);
        check("stall_first_pix", {pix_valid, pix_R, pix_G, pix_B, pix_sof, pix_sol},
              {1'b1, 24'h112233, 1'b1, 1'b1});
        pix_ready = 1'b1;
        @(posedge Clock); @(negedge Clock);
        check("second_pix", {pix_valid, pix_R, pix_G, pix_B, pix_sof, pix_sol},
              {1'b1, 24'h445566, 1'b0, 1'b0});
        for (int c = 0; c < 2000 && done_cnt == 0; c++) @(posedge Clock);
        #1;
        check("stall_pix_count", acc_idx, NPIX);
        check("stall_done_count", done_cnt, 1);

        // Short reset in the middle of a frame, then a fresh frame.
        start_frame(1'b1);
        for (int c = 0; c < 500 && acc_idx < 10; c++) begin
            @(posedge Clock); #1;
        end
        check("reached_pix10", acc_idx >= 10, 1);
        Resetn = 1'b0;
        #1 check("midframe_reset_outputs", outs, RESET_OUTS);
        #2 Resetn = 1'b1;
        run_frame(0, -1);
        check("restart_pix_count", acc_idx, NPIX);
        check("restart_sof_count", sof_cnt, 1);
        check("restart_done_count", done_cnt, 1);
        check("restart_last_addr", SRAM_address, LAST_ADDR);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
